fp_dec_format: RTL
==================

FP_DEC_FORMAT -- requirements
Module: fp_dec_format

Interface
REQ-001 SHALL have: CLK  in  1  clock; all state updates on rising edge.
REQ-002 SHALL have: RST  in  1  reset, asynchronous, active-low.
REQ-003 SHALL have: in_valid  in  1  upstream result available.
REQ-004 SHALL have: in_ready  out  1  block can accept; combinational, high only in IDLE.
REQ-005 SHALL have: sign_in  in  1  sign of the converted number.
REQ-006 SHALL have: nguyen  in  5  binary integer part, 0..31.
REQ-007 SHALL have: le  in  20  binary fractional digits as integer, 0..1048575.
REQ-008 SHALL have: lt  in  9  binary magnitude of the negative decimal exponent, 0..511.
REQ-009 SHALL have: out_valid  out  1  formatted result available; high only in DONE.
REQ-010 SHALL have: out_ready  in  1  downstream accepts the result.
REQ-011 SHALL have: sign_out  out  1  registered sign_in.
REQ-012 SHALL have: int_bcd  out  8  2 BCD digits of nguyen, MSD in [7:4].
REQ-013 SHALL have: frac_bcd  out  28  7 BCD digits of le, MSD in [27:24].
REQ-014 SHALL have: exp_bcd  out  12  3 BCD digits of lt, MSD in [11:8].
REQ-015 SHALL have: busy  out  1  high in CONV_LE, CONV_INT, CONV_EXP.

Function
REQ-016 SHALL implement FSM states IDLE, CONV_LE, CONV_INT, CONV_EXP, DONE.
REQ-017 SHALL accept on the edge where in_valid & in_ready: latch sign_in, nguyen, le, lt; clear BCD work registers; enter CONV_LE.
REQ-018 SHALL convert by sequential shift-add-3: per edge, add 3 to each work BCD digit >= 5, then shift left one bit, MSB of the binary operand entering at the LSB.
REQ-019 SHALL spend exactly 20 edges in CONV_LE (le), 5 in CONV_INT (nguyen), 9 in CONV_EXP (lt), with a 5-bit step counter reloaded on each state entry.
REQ-020 SHALL transition to the next state on the edge performing the last step of the current state.
REQ-021 SHALL, with accept at edge 0, enter DONE at edge 34 and assert out_valid from then.
REQ-022 SHALL load sign_out, int_bcd, frac_bcd and exp_bcd in one edge on DONE entry, and hold them stable in DONE.
REQ-023 SHALL hold DONE with out_valid high while out_ready is low, with no output change.
REQ-024 SHALL return to IDLE on the edge where out_valid & out_ready; in_ready rises in the following cycle, so no accept occurs in the same cycle.
REQ-025 SHALL keep output registers at the last result in IDLE and during conversion until the next DONE entry.
REQ-026 SHALL ignore in_valid and input changes outside IDLE.
REQ-027 SHALL produce exact BCD for the full input ranges; no saturation or overflow flag.

Reset
REQ-028 SHALL, on RST low at any time including mid-conversion or in DONE, immediately force IDLE and clear all work registers and counters.
REQ-029 SHALL reset outputs: out_valid=0, busy=0, sign_out=0, int_bcd=0, frac_bcd=0, exp_bcd=0; in_ready=1 (IDLE).
REQ-030 SHALL resume normal operation on the first rising edge after RST deasserts, with no pending result.

Configuration
REQ-031 SHALL, with FP_DEC_EXP_EN defined, include CONV_EXP and the exponent work registers as in REQ-019 and REQ-021.
REQ-032 SHALL, without FP_DEC_EXP_EN, omit CONV_EXP and the exponent logic, pass from CONV_INT to DONE, enter DONE at edge 25, and tie exp_bcd to 0.

Verification
REQ-033 SHALL test: nguyen=7, le=999999, lt=3, sign_in=1, out_ready=1 -> out_valid at edge 34; int_bcd=0x07, frac_bcd=0x0999999, exp_bcd=0x003, sign_out=1.
REQ-034 SHALL test: nguyen=31, le=1048575, lt=511 -> int_bcd=0x31, frac_bcd=0x1048575, exp_bcd=0x511.
REQ-035 SHALL test: all inputs 0 -> all BCD outputs 0, latency 34.
REQ-036 SHALL test: out_ready low 10 cycles after out_valid -> outputs and out_valid stable; in_ready low; IDLE one edge after out_ready=1.
REQ-037 SHALL test: RST pulsed low at edge 10 of a conversion -> in_ready=1, busy=0, out_valid=0, outputs 0; next transaction (le=12345) -> frac_bcd=0x0012345.
REQ-038 SHALL test: build without FP_DEC_EXP_EN, lt=123 -> out_valid at edge 25, exp_bcd=0.

Source files
------------

// File: rtl/fp_dec_format_if.sv
// Handshake and data bundle for the binary-to-BCD result formatter.
interface fp_dec_format_if;
  logic        in_valid;
  logic        in_ready;
  logic        sign_in;
  logic [4:0]  nguyen;
  logic [19:0] le;
  logic [8:0]  lt;
  logic        out_valid;
  logic        out_ready;
  logic        sign_out;
  logic [7:0]  int_bcd;
  logic [27:0] frac_bcd;
  logic [11:0] exp_bcd;
  logic        busy;

  modport master (
    output in_valid, sign_in, nguyen, le, lt, out_ready,
    input  in_ready, out_valid, sign_out, int_bcd, frac_bcd, exp_bcd, busy
  );
  modport slave (
    input  in_valid, sign_in, nguyen, le, lt, out_ready,
    output in_ready, out_valid, sign_out, int_bcd, frac_bcd, exp_bcd, busy
  );
endinterface

// File: rtl/fp_dec_format.sv
// Sequential shift-add-3 conversion of fraction, integer and exponent to BCD.
// FP_DEC_EXP_EN enables the exponent conversion stage; otherwise exp_bcd is 0.
module fp_dec_format (
  input logic            CLK,
  input logic            RST,
  fp_dec_format_if.slave bus
);
  typedef enum logic [2:0] {
    IDLE, CONV_LE, CONV_INT,
`ifdef FP_DEC_EXP_EN
    CONV_EXP,
`endif
    DONE
  } state_t;

  function automatic logic [3:0] adj(input logic [3:0] d);
    return (d >= 4'd5) ? d + 4'd3 : d;
  endfunction

  state_t      state_q, state_d;
  logic [4:0]  cnt_q, cnt_d;
  logic        sign_q, sign_d;
  logic [4:0]  ng_q, ng_d;
  logic [19:0] le_q, le_d;
  logic [27:0] le_w_q, le_w_d, le_adj;
  logic [7:0]  int_w_q, int_w_d, int_adj;
  logic        out_valid_q, out_valid_d;
  logic        busy_q, busy_d;
  logic        sign_out_q, sign_out_d;
  logic [7:0]  int_bcd_q, int_bcd_d;
  logic [27:0] frac_bcd_q, frac_bcd_d;
  logic [11:0] exp_bcd_q, exp_bcd_d;
`ifdef FP_DEC_EXP_EN
  logic [8:0]  lt_q, lt_d;
  logic [11:0] exp_w_q, exp_w_d, exp_adj;
`endif

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    sign_d     = sign_q;
    ng_d       = ng_q;
    le_d       = le_q;
    le_w_d     = le_w_q;
    int_w_d    = int_w_q;
    sign_out_d = sign_out_q;
    int_bcd_d  = int_bcd_q;
    frac_bcd_d = frac_bcd_q;
    exp_bcd_d  = exp_bcd_q;
    le_adj     = '0;
    int_adj    = '0;
    for (int i = 0; i < 7; i++) le_adj[4*i +: 4] = adj(le_w_q[4*i +: 4]);
    for (int i = 0; i < 2; i++) int_adj[4*i +: 4] = adj(int_w_q[4*i +: 4]);
`ifdef FP_DEC_EXP_EN
    lt_d    = lt_q;
    exp_w_d = exp_w_q;
    exp_adj = '0;
    for (int i = 0; i < 3; i++) exp_adj[4*i +: 4] = adj(exp_w_q[4*i +: 4]);
`endif

    // Operand bits are consumed MSB first: the down-counter doubles as bit index.
    case (state_q)
      IDLE: if (bus.in_valid) begin
        sign_d  = bus.sign_in;
        ng_d    = bus.nguyen;
        le_d    = bus.le;
        le_w_d  = '0;
        int_w_d = '0;
`ifdef FP_DEC_EXP_EN
        lt_d    = bus.lt;
        exp_w_d = '0;
`endif
        cnt_d   = 5'd19;
        state_d = CONV_LE;
      end
      CONV_LE: begin
        le_w_d = (le_adj << 1) | 28'(le_q[cnt_q]);
        if (cnt_q == 5'd0) begin
          state_d = CONV_INT;
          cnt_d   = 5'd4;
        end else cnt_d = cnt_q - 5'd1;
      end
      CONV_INT: begin
        int_w_d = (int_adj << 1) | 8'(ng_q[cnt_q[2:0]]);
        if (cnt_q == 5'd0) begin
`ifdef FP_DEC_EXP_EN
          state_d = CONV_EXP;
          cnt_d   = 5'd8;
`else
          state_d = DONE;
          cnt_d   = 5'd0;
`endif
        end else cnt_d = cnt_q - 5'd1;
      end
`ifdef FP_DEC_EXP_EN
      CONV_EXP: begin
        exp_w_d = (exp_adj << 1) | 12'(lt_q[cnt_q[3:0]]);
        if (cnt_q == 5'd0) state_d = DONE;
        else cnt_d = cnt_q - 5'd1;
      end
`endif
      DONE: if (bus.out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Results are captured from the final-step values so DONE shows them at once.
    if (state_d == DONE && state_q != DONE) begin
      sign_out_d = sign_q;
      int_bcd_d  = int_w_d;
      frac_bcd_d = le_w_d;
`ifdef FP_DEC_EXP_EN
      exp_bcd_d  = exp_w_d;
`else
      exp_bcd_d  = '0;
`endif
    end

    out_valid_d = (state_d == DONE);
    busy_d      = (state_d != IDLE) && (state_d != DONE);
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      sign_q      <= 1'b0;
      ng_q        <= '0;
      le_q        <= '0;
      le_w_q      <= '0;
      int_w_q     <= '0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      sign_out_q  <= 1'b0;
      int_bcd_q   <= '0;
      frac_bcd_q  <= '0;
      exp_bcd_q   <= '0;
`ifdef FP_DEC_EXP_EN
      lt_q        <= '0;
      exp_w_q     <= '0;
`endif
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      sign_q      <= sign_d;
      ng_q        <= ng_d;
      le_q        <= le_d;
      le_w_q      <= le_w_d;
      int_w_q     <= int_w_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
      sign_out_q  <= sign_out_d;
      int_bcd_q   <= int_bcd_d;
      frac_bcd_q  <= frac_bcd_d;
      exp_bcd_q   <= exp_bcd_d;
`ifdef FP_DEC_EXP_EN
      lt_q        <= lt_d;
      exp_w_q     <= exp_w_d;
`endif
    end
  end

  assign bus.in_ready  = (state_q == IDLE);
  assign bus.out_valid = out_valid_q;
  assign bus.busy      = busy_q;
  assign bus.sign_out  = sign_out_q;
  assign bus.int_bcd   = int_bcd_q;
  assign bus.frac_bcd  = frac_bcd_q;
`ifdef FP_DEC_EXP_EN
  assign bus.exp_bcd   = exp_bcd_q;
`else
  assign bus.exp_bcd   = 12'd0;
`endif
endmodule
